sequencer_step_player: RTL and testbench

//  Consumer end of the beat-pulse interface: counts tempo beats into a step position within one measure.

---
 rtl/sequencer_step_player_if.sv | 31 +++
 rtl/sequencer_step_player.sv | 136 +++++++++++++
 tb/tb_sequencer_step_player.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sequencer_step_player_if.sv
// Beat/keypad-to-sequencer bus: control strobes in, step/note presentation out.
interface sequencer_step_player_if #(
    parameter int unsigned STEPS  = 8,
    parameter int unsigned NOTE_W = 4
);
    localparam int unsigned SW = $clog2(STEPS);

    logic              sequencer_on;
    logic              beat_pulse;
    logic              record_en;
    logic              key_valid;
    logic [NOTE_W-1:0] key_code;
    logic              clear_pattern;
    logic [SW-1:0]     step_idx;
    logic [NOTE_W-1:0] note_out;
    logic              note_active;
    logic              measure_pulse;
    logic              busy;

    // Control side (tempo divider, keypad decoder, mode switch)
    modport master (
        output sequencer_on, beat_pulse, record_en, key_valid, key_code, clear_pattern,
        input  step_idx, note_out, note_active, measure_pulse, busy
    );

    // Sequencer side
    modport slave (
        input  sequencer_on, beat_pulse, record_en, key_valid, key_code, clear_pattern,
        output step_idx, note_out, note_active, measure_pulse, busy
    );
endinterface

// File: rtl/sequencer_step_player.sv
// Step sequencer: counts beats into a step position, stores/records a note
// pattern and presents the current step's note. All outputs are registered;
// the output registers load from the next-state values so they always match
// the step and pattern they describe.
module sequencer_step_player #(
    parameter int unsigned STEPS  = 8,
    parameter int unsigned NOTE_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    sequencer_step_player_if.slave bus
);
    localparam int unsigned SW = $clog2(STEPS);
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [STEPS-1:0]  valid_q, valid_d;
    logic [NOTE_W-1:0] code_q [STEPS];
    logic [NOTE_W-1:0] code_d [STEPS];
    logic [NOTE_W-1:0] note_q, note_d;
    logic              active_q, active_d;
    logic              measure_q, measure_d;
    logic              busy_q, busy_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, step/pattern update and next output values
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        code_d    = code_q;
        measure_d = 1'b0;

        case (state_q)
            IDLE: begin
                step_d = '0;
                if (bus.clear_pattern) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (bus.sequencer_on) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus.clear_pattern) begin
                    state_d = CLEAR;
                    step_d  = '0;
                    cnt_d   = '0;
                end else if (!bus.sequencer_on) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else begin
                    // Record targets the pre-advance step
                    if (bus.record_en && bus.key_valid) begin
                        if (bus.key_code != '0) begin
                            code_d[step_q]  = bus.key_code;
                            valid_d[step_q] = 1'b1;
                        end else begin
                            valid_d[step_q] = 1'b0;
                        end
                    end
                    if (bus.beat_pulse) begin
                        if (step_q == LAST) begin
                            step_d    = '0;
                            measure_d = 1'b1;
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end
                end
            end
            CLEAR: begin
                step_d         = '0;
                valid_d[cnt_q] = 1'b0;
                code_d[cnt_q]  = '0;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = bus.sequencer_on ? PLAY : IDLE;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase

        note_d   = valid_d[step_d] ? code_d[step_d] : '0;
        active_d = (state_d == PLAY) && valid_d[step_d];
        busy_d   = (state_d == CLEAR);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= '0;
            code_q    <= '{default: '0};
            note_q    <= '0;
            active_q  <= 1'b0;
            measure_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            note_q    <= note_d;
            active_q  <= active_d;
            measure_q <= measure_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.step_idx      = step_q;
    assign bus.note_out      = note_q;
    assign bus.note_active   = active_q;
    assign bus.measure_pulse = measure_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_sequencer_step_player.sv
// Directed bench for sequencer_step_player (STEPS=8, NOTE_W=4).
module tb_sequencer_step_player;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sequencer_step_player_if #(.STEPS(8), .NOTE_W(4)) bus ();

    sequencer_step_player #(.STEPS(8), .NOTE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One clock, then settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n back-to-back beats with no key strobes
    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            bus.beat_pulse = 1'b1;
            tick();
        end
        bus.beat_pulse = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] step, input logic [3:0] note,
                           input logic act, input logic meas, input logic bsy);
        chk({tag, ".step"},    32'(bus.step_idx),      32'(step));
        chk({tag, ".note"},    32'(bus.note_out),      32'(note));
        chk({tag, ".active"},  32'(bus.note_active),   32'(act));
        chk({tag, ".measure"}, 32'(bus.measure_pulse), 32'(meas));
        chk({tag, ".busy"},    32'(bus.busy),          32'(bsy));
    endtask

    initial begin
        rst               = 1'b1;
        bus.sequencer_on  = 1'b0;
        bus.beat_pulse    = 1'b0;
        bus.record_en     = 1'b0;
        bus.key_valid     = 1'b0;
        bus.key_code      = 4'h0;
        bus.clear_pattern = 1'b0;
        tick();
        tick();
        chk_out("reset", 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("idle", 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Wrap: back-to-back beats, measure_pulse only on the wrap
        bus.sequencer_on = 1'b1;
        tick();
        chk_out("enter_play", 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.beat_pulse = 1'b1;
            tick();
            chk("wrap.step",    32'(bus.step_idx),      32'((i + 1) % 8));
            chk("wrap.measure", 32'(bus.measure_pulse), 32'(i == 7));
        end
        bus.beat_pulse = 1'b0;
        tick();
        chk_out("wrap_hold", 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Record code 9 at step 2
        bus.record_en = 1'b1;
        beats(2);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h9;
        tick();
        bus.key_valid = 1'b0;
        chk_out("rec9", 3'd2, 4'h9, 1'b1, 1'b0, 1'b0);
        beats(8);
        chk_out("rec9_revisit", 3'd2, 4'h9, 1'b1, 1'b0, 1'b0);

        // Collision at step 3: write hits step 3, step advances to 4
        beats(1);
        chk_out("at3", 3'd3, 4'h0, 1'b0, 1'b0, 1'b0);
        bus.beat_pulse = 1'b1;
        bus.key_valid  = 1'b1;
        bus.key_code   = 4'h5;
        tick();
        bus.beat_pulse = 1'b0;
        bus.key_valid  = 1'b0;
        chk_out("coll_step4", 3'd4, 4'h0, 1'b0, 1'b0, 1'b0);
        beats(7);
        chk_out("coll_revisit3", 3'd3, 4'h5, 1'b1, 1'b0, 1'b0);

        // Fill all 8 steps (codes 1..8 from step 3 onward), then clear
        for (int i = 0; i < 8; i++) begin
            bus.beat_pulse = 1'b1;
            bus.key_valid  = 1'b1;
            bus.key_code   = 4'(i + 1);
            tick();
        end
        bus.beat_pulse = 1'b0;
        bus.key_valid  = 1'b0;
        chk_out("filled3", 3'd3, 4'h1, 1'b1, 1'b0, 1'b0);
        beats(1);
        chk_out("filled4", 3'd4, 4'h2, 1'b1, 1'b0, 1'b0);

        bus.clear_pattern = 1'b1;
        tick();
        bus.clear_pattern = 1'b0;
        chk("clr.busy0", 32'(bus.busy), 32'd1);
        chk("clr.step0", 32'(bus.step_idx), 32'd0);
        for (int i = 1; i < 8; i++) begin
            bus.beat_pulse = (i <= 3);
            bus.key_valid  = (i == 2);
            bus.key_code   = 4'hF;
            tick();
            chk("clr.busy", 32'(bus.busy), 32'd1);
            chk("clr.step", 32'(bus.step_idx), 32'd0);
        end
        bus.beat_pulse = 1'b0;
        bus.key_valid  = 1'b0;
        tick();
        chk_out("clr_done", 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.beat_pulse = 1'b1;
            tick();
            chk("clr_scan.step",   32'(bus.step_idx),    32'((i + 1) % 8));
            chk("clr_scan.note",   32'(bus.note_out),    32'd0);
            chk("clr_scan.active", 32'(bus.note_active), 32'd0);
        end
        bus.beat_pulse = 1'b0;

        // Mode exit at step 6, pattern retained
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h7;
        tick();
        bus.key_valid = 1'b0;
        chk_out("rec7_s0", 3'd0, 4'h7, 1'b1, 1'b0, 1'b0);
        beats(6);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h3;
        tick();
        bus.key_valid = 1'b0;
        chk_out("rec3_s6", 3'd6, 4'h3, 1'b1, 1'b0, 1'b0);
        bus.sequencer_on = 1'b0;
        tick();
        chk_out("exit_idle", 3'd0, 4'h7, 1'b0, 1'b0, 1'b0);
        bus.beat_pulse = 1'b1;
        bus.key_valid  = 1'b1;
        bus.key_code   = 4'h2;
        tick();
        bus.beat_pulse = 1'b0;
        bus.key_valid  = 1'b0;
        chk_out("idle_ignore", 3'd0, 4'h7, 1'b0, 1'b0, 1'b0);
        bus.sequencer_on = 1'b1;
        tick();
        chk_out("reenter", 3'd0, 4'h7, 1'b1, 1'b0, 1'b0);
        beats(6);
        chk_out("replay_s6", 3'd6, 4'h3, 1'b1, 1'b0, 1'b0);
        // Erase with key code 0
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h0;
        tick();
        bus.key_valid = 1'b0;
        chk_out("erase_s6", 3'd6, 4'h0, 1'b0, 1'b0, 1'b0);

        // Reset mid-PLAY at step 5 with a stored note
        beats(7);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'hA;
        tick();
        bus.key_valid = 1'b0;
        chk_out("recA_s5", 3'd5, 4'hA, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("rst_mid", 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("rst_release", 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.beat_pulse = 1'b1;
            tick();
            chk("rst_scan.step", 32'(bus.step_idx), 32'((i + 1) % 8));
            chk("rst_scan.note", 32'(bus.note_out), 32'd0);
        end
        bus.beat_pulse = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
